bin2bcd_seq: RTL
================

Name: bin2bcd_seq

Overview:
Sequential, parametrised binary-to-BCD converter using iterative shift-add-3 (double-dabble), one bit per clock. It also produces LCD-ready ASCII with optional leading-zero blanking and an overflow/saturation flag. It sits between timing/counter logic and the LCD controller's character-packing path, and replaces combinational conversion with a Start/Busy/Done handshake.

Parameters:
BIN_W, 10, width of binary input (1..32)
DIGITS, 4, number of BCD output digits (1..10)
BLANK, 1, 1 = leading zeros shown as ASCII space (0x20); 0 = shown as '0' (0x30)

Ports:
Clk  input  1  system clock, all state on rising edge
Rst  input  1  asynchronous, active-low reset
Start  input  1  request conversion of Binary; sampled only when accepting (see Behaviour)
Binary  input  BIN_W  unsigned value, captured in the Start-accept cycle only
Busy  output  1  high while a conversion is in progress (SHIFT state)
Done  output  1  one-cycle pulse; BCD/Ascii/Overflow are valid and updated in this cycle
BCD  output  4*DIGITS  packed BCD, most significant digit in top nibble
Ascii  output  8*DIGITS  one character per digit, most significant digit in top byte
Overflow  output  1  high if the last converted value was >= 10^DIGITS

Behaviour:
- Reset (Rst=0, async): state IDLE; Busy=0, Done=0, Overflow=0, BCD=0; Ascii = all 0x20 except LSD 0x30 when BLANK=1, all 0x30 when BLANK=0. Internal shift/count registers cleared.
- States: IDLE, SHIFT, DONE.
- IDLE: Start=1 -> capture Binary into shift register, clear the digit accumulator and overflow sticky bit, clear the bit counter, go to SHIFT. Start=0 -> stay.
- SHIFT: Busy=1. Each cycle: add 3 to every digit >4, then shift {digits, binary} left by 1. If a 1 is shifted out of the top digit, set the overflow sticky bit. After exactly BIN_W shift cycles, go to DONE. Start is ignored while in SHIFT.
- DONE: one cycle. Done=1, Busy=0. Outputs are registered on entry to this cycle.
  - No overflow: BCD = accumulator; Overflow=0.
  - Overflow: BCD = all 9s; Overflow=1.
- DONE exit: Start=1 in DONE is accepted exactly as in IDLE (back-to-back; the next Done follows BIN_W+1 cycles later). Start=0 -> IDLE.
- Latency: Start accepted in cycle N -> Done=1 in cycle N+BIN_W+1. Minimum period between Done pulses is BIN_W+1 cycles.
- Ascii: digit d maps to 0x30+d. With BLANK=1, a digit is 0x20 if it and all more-significant digits are 0. The LSD is never blanked, so 0 renders as "   0". Overflow renders as all '9'.
- Hold: BCD/Ascii/Overflow keep their last values between Done pulses, including during SHIFT. Binary changes after the accept cycle have no effect.
- Reset mid-conversion: abort immediately to reset values; no Done is issued.
- Width rule: the accumulator is 4*DIGITS bits. Overflow detection covers the case where DIGITS is too small for BIN_W. No truncation of the high-order digits may go unflagged.

Test Plan:
- BIN_W=10, DIGITS=4: Start with Binary=0 -> Done 11 cycles later, BCD=0x0000, Ascii="   0", Overflow=0.
- BIN_W=10, DIGITS=4: Binary=1023 -> BCD=0x1023, Ascii="1023". Busy high for exactly 10 cycles. Done high for exactly 1 cycle.
- BIN_W=10, DIGITS=3: Binary=1023 -> Overflow=1, BCD=0x999, Ascii="999". Follow-up Binary=999 -> Overflow=0, BCD=0x999.
- Start held high continuously with Binary = 5, 57, 305 changing each accept -> back-to-back Done every 11 cycles with BCD 0x0005, 0x0057, 0x0305. Ascii "   5", "  57", " 305". Binary toggling mid-SHIFT does not corrupt results.
- BLANK=0, Binary=42 -> Ascii="0042". Start pulsed during SHIFT -> ignored, with no extra Done.
- Rst asserted at shift cycle 4 of a conversion of 812 -> all outputs at reset values within the same cycle, no Done. A fresh Start after release converts 812 correctly.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary to BCD/ASCII converter with start/busy/done handshake
module bin2bcd_seq #(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 4,
  parameter int BLANK  = 1
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Start,
  input  logic [BIN_W-1:0]      Binary,
  output logic                  Busy,
  output logic                  Done,
  output logic [4*DIGITS-1:0]   BCD,
  output logic [8*DIGITS-1:0]   Ascii,
  output logic                  Overflow
);

  localparam int         ACC_W    = 4 * DIGITS;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;
  localparam logic [5:0] LAST_CNT = 6'(BIN_W - 1);

  logic [1:0]       state_q;
  logic [BIN_W-1:0] bin_q;
  logic [ACC_W-1:0] acc_q;
  logic             ovf_q;
  logic [5:0]       cnt_q;

  logic [ACC_W-1:0] acc_adj;
  logic [ACC_W-1:0] acc_sh;
  logic [BIN_W-1:0] bin_sh;
  logic             shout;
  logic             ovf_nxt;
  logic [ACC_W-1:0] bcd_final;

  // Render packed BCD as characters; leading zeros optionally become spaces, LSD always shown.
  function automatic logic [8*DIGITS-1:0] to_ascii(input logic [ACC_W-1:0] b);
    logic       lead;
    logic [3:0] d;
    to_ascii = '0;
    lead     = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d = b[4*i +: 4];
      if (d != 4'd0 || i == 0) lead = 1'b0;
      to_ascii[8*i +: 8] = (lead && BLANK != 0) ? 8'h20 : {4'h3, d};
    end
  endfunction

  // One double-dabble step: add 3 to digits above 4, then shift {digits, binary} left.
  // A 1 leaving the top digit means the value needs more digits than we have.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] > 4'd4) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    {shout, acc_sh, bin_sh} = {acc_adj, bin_q, 1'b0};
    ovf_nxt   = ovf_q | shout;
    bcd_final = ovf_nxt ? {DIGITS{4'h9}} : acc_sh;
  end

  assign Busy = (state_q == S_SHIFT);
  assign Done = (state_q == S_DONE);

  // Handshake FSM, shift datapath and output registers updated on entry to DONE.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= S_IDLE;
      bin_q    <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      BCD      <= '0;
      Ascii    <= to_ascii('0);
      Overflow <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (Start) begin
            bin_q   <= Binary;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_SHIFT;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_SHIFT: begin
          bin_q <= bin_sh;
          acc_q <= acc_sh;
          ovf_q <= ovf_nxt;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == LAST_CNT) begin
            state_q  <= S_DONE;
            BCD      <= bcd_final;
            Ascii    <= to_ascii(bcd_final);
            Overflow <= ovf_nxt;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
